// File: rtl/recover_2n_pkg.sv
// Shared types and helpers for the recover_2n_FFT frame sequencer.
// Holds the sequencer state enum, default frame geometry and the index bit-reversal.
package recover_2n_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } seq_state_t;

    localparam int N_BEATS_DEF    = 1025;
    localparam int HEAD_BEATS_DEF = 2;

    function automatic logic [10:0] bitrev11(input logic [10:0] x);
        logic [10:0] r;
        for (int i = 0; i < 11; i++) begin
            r[i] = x[10-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/recover_seq_dly.sv
// Fixed-depth shift register that keeps {valid, head} aligned with buffer/ROM read data.
// A flush clears every stage so no stale beat reaches the datapath after an abort.
module recover_seq_dly #(
    parameter int DEPTH = 1,
    parameter int W     = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [DEPTH-1:0][W-1:0] sr;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            sr <= '0;
        end else begin
            sr[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/recover_2n_fft_seq.sv
// Frame sequencer for recover_2n_FFT: issues one frame of buffer/index-ROM reads, then
// watches the datapath ready window and reports done, a count error or a timeout.
module recover_2n_fft_seq
    import recover_2n_pkg::*;
#(
    parameter int N_BEATS    = N_BEATS_DEF,
    parameter int HEAD_BEATS = HEAD_BEATS_DEF,
    parameter int GADDR_W    = 11,
    parameter int IDX_W      = 11,
    parameter int RD_LAT     = 1,
    parameter int TIMEOUT    = 4096
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    output logic               rd_en,
    output logic               rd_col2_en,
    output logic [GADDR_W-1:0] rd_addr_col1,
    output logic [GADDR_W-1:0] rd_addr_col2,
    output logic [IDX_W-1:0]   idx_rom_addr,
    input  logic [IDX_W-1:0]   idx_rom_col1,
    input  logic [IDX_W-1:0]   idx_rom_col2,
    output logic               dp_valid,
    output logic [IDX_W-1:0]   dp_index_col_1,
    output logic [IDX_W-1:0]   dp_index_col_2,
    input  logic               dp_ready,
    output logic               busy,
    output logic               done,
    output logic               cnt_err,
    output logic               timeout_err
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int CNT_W = $clog2(N_BEATS + 1) + 1;

    seq_state_t         state, state_nxt;
    logic [IDX_W-1:0]   beat;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [CNT_W-1:0]   out_cnt;
    logic               ready_seen;
    logic               start_ok, last_beat, ready_fall, tmo_hit;
    logic               issuing, head;
    logic [GADDR_W-1:0] body_addr;
    logic               dly_valid, dly_head;

    assign start_ok   = (state == S_IDLE) && start && !abort;
    assign last_beat  = (beat == IDX_W'(N_BEATS - 1));
    assign ready_fall = ready_seen && !dp_ready;
    assign tmo_hit    = !ready_seen && !dp_ready && (tmo_cnt >= TMO_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_ok) state_nxt = S_ISSUE;
            S_ISSUE: if (last_beat) state_nxt = S_DRAIN;
            S_DRAIN: begin
                if (ready_fall) begin
                    state_nxt = (out_cnt == CNT_W'(N_BEATS)) ? S_DONE : S_IDLE;
                end else if (tmo_hit) begin
                    state_nxt = S_IDLE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort) begin
            state_nxt = S_IDLE;
        end
    end

    // Beat, drain counters and sticky flags; flags survive abort and clear only on an accepted start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat        <= '0;
            tmo_cnt     <= '0;
            out_cnt     <= '0;
            ready_seen  <= 1'b0;
            cnt_err     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (start_ok) begin
                beat        <= '0;
                cnt_err     <= 1'b0;
                timeout_err <= 1'b0;
            end else if (state == S_ISSUE && !last_beat) begin
                beat <= beat + 1'b1;
            end

            if (state != S_DRAIN) begin
                tmo_cnt    <= '0;
                out_cnt    <= '0;
                ready_seen <= 1'b0;
            end else begin
                if (tmo_cnt != TMO_W'(TIMEOUT)) tmo_cnt <= tmo_cnt + 1'b1;
                if (dp_ready) begin
                    ready_seen <= 1'b1;
                    if (out_cnt != '1) out_cnt <= out_cnt + 1'b1;
                end
                if (!abort) begin
                    if (ready_fall && out_cnt != CNT_W'(N_BEATS)) cnt_err <= 1'b1;
                    else if (tmo_hit) timeout_err <= 1'b1;
                end
            end
        end
    end

    // The first body beat re-reads groups 0/1; later body beats step two groups at a time.
    assign issuing   = (state == S_ISSUE);
    assign head      = (beat < IDX_W'(HEAD_BEATS));
    assign body_addr = GADDR_W'({beat - IDX_W'(HEAD_BEATS), 1'b0});

    assign rd_en        = issuing;
    assign rd_col2_en   = issuing && !head;
    assign rd_addr_col1 = !issuing ? '0 : (head ? GADDR_W'(beat) : body_addr);
    assign rd_addr_col2 = (issuing && !head) ? (body_addr | GADDR_W'(1)) : '0;
    assign idx_rom_addr = issuing ? beat : '0;
    assign busy         = (state != S_IDLE);
    assign done         = (state == S_DONE);

    recover_seq_dly #(
        .DEPTH (RD_LAT),
        .W     (2)
    ) u_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (abort),
        .d     ({issuing, head}),
        .q     ({dly_valid, dly_head})
    );

    assign dp_valid       = dly_valid;
    assign dp_index_col_1 = dly_valid ? bitrev11(idx_rom_col1) : '0;
    assign dp_index_col_2 = (dly_valid && !dly_head) ? bitrev11(idx_rom_col2) : '0;

endmodule
